// File: rtl/adc045_acq_seq.sv
// adc045_acq_seq
// Bring-up sequencer and sample capture stage in front of adc045_wrap.
// After reset (and while enable=1) it walks the ADC through power-up wait,
// reset pulse, register write and conversion start. It then captures every
// rising edge of ready_sample into a one-deep valid/ready output register.
// A watchdog on ready_sample re-runs the bring-up. After MAX_RETRY re-runs
// with no recovery it parks in FAULT.
//
// Optional build macro: ADC045_AVG4_EN
//   When defined, four consecutive captured samples are summed (26-bit
//   signed) and their arithmetic mean (sum >>> 2) is emitted instead of
//   every sample.
//
// Output handshake (valid/ready):
//   smp_valid rises when a sample is loaded, and stays high with smp_data
//   frozen until a cycle in which smp_valid & smp_ready are both 1. That
//   cycle is the transfer. A new sample may load in the transfer cycle
//   itself, keeping smp_valid high. A sample that arrives while an
//   untransferred one is pending is dropped, and overrun_err is flagged.

module adc045_acq_seq #(
  parameter int PWRUP_CYC     = 4000,
  parameter int RST_LOW_CYC   = 1,
  parameter int RST_WAIT_CYC  = 1000,
  parameter int WREG_WAIT_CYC = 500,
  parameter int TIMEOUT_CYC   = 20000,
  parameter int MAX_RETRY     = 3,
  parameter int CNT_W         = 16
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        enable,
  input  logic        restart,
  output logic        rst_l_adc,
  output logic        hard_wreg,
  output logic        hard_start,
  input  logic        ready_sample,
  input  logic [23:0] adc045_data,
  output logic        smp_valid,
  output logic [23:0] smp_data,
  input  logic        smp_ready,
  output logic [2:0]  seq_state,
  output logic        timeout_err,
  output logic        overrun_err,
  input  logic        err_clr,
  output logic [31:0] sample_cnt
);

  // Down-counter reload values: a state lasting N cycles loads N-1 on entry
  // and exits when the counter reads zero.
  localparam logic [CNT_W-1:0] PWRUP_LD     = CNT_W'(PWRUP_CYC - 1);
  localparam logic [CNT_W-1:0] RST_LOW_LD   = CNT_W'(RST_LOW_CYC - 1);
  localparam logic [CNT_W-1:0] RST_WAIT_LD  = CNT_W'(RST_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] WREG_WAIT_LD = CNT_W'(WREG_WAIT_CYC - 1);
  // In RUN the same counter counts up. It expires on its TIMEOUT_CYC-th
  // cycle without a ready_sample rise.
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  localparam int               RTY_W   = $clog2(MAX_RETRY + 2);
  localparam logic [RTY_W-1:0] RTY_MAX = RTY_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PWRUP     = 3'd1,
    S_ADC_RST   = 3'd2,
    S_RST_WAIT  = 3'd3,
    S_WREG      = 3'd4,
    S_WREG_WAIT = 3'd5,
    S_RUN       = 3'd6,
    S_FAULT     = 3'd7
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RTY_W-1:0] retry_q, retry_d;
  logic             rdy_q;
  logic             rise;
  logic             timeout_evt;
  logic             new_smp;
  logic [23:0]      new_val;
  logic             transfer;
  logic             overrun_set;

  assign seq_state = state_q;
  assign rise      = ready_sample & ~rdy_q;
  assign transfer  = smp_valid & smp_ready;

  // State, wait counter, retry counter and ready_sample edge register.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      retry_q <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      rdy_q   <= ready_sample;
    end
  end

  // Next-state, counter and watchdog logic. enable=0 beats restart, and
  // restart beats the normal sequence.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    retry_d     = retry_q;
    timeout_evt = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_PWRUP;
          cnt_d   = PWRUP_LD;
        end
      end
      S_PWRUP: begin
        if (cnt_q == '0) begin
          state_d = S_ADC_RST;
          cnt_d   = RST_LOW_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_ADC_RST: begin
        if (cnt_q == '0) begin
          state_d = S_RST_WAIT;
          cnt_d   = RST_WAIT_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_WREG;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_WREG: begin
        state_d = S_WREG_WAIT;
        cnt_d   = WREG_WAIT_LD;
      end
      S_WREG_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RUN: begin
        if (rise) begin
          // A live ADC proves the bring-up worked: forget earlier retries.
          cnt_d   = '0;
          retry_d = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          timeout_evt = 1'b1;
          cnt_d       = RST_LOW_LD;
          if (retry_q < RTY_MAX) begin
            retry_d = retry_q + RTY_W'(1);
            state_d = S_ADC_RST;
          end else begin
            state_d = S_FAULT;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (restart && (state_q != S_IDLE)) begin
      state_d = S_ADC_RST;
      cnt_d   = RST_LOW_LD;
      retry_d = '0;
    end

    if (!enable) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      retry_d = '0;
    end
  end

  // ADC control pins are registered from the next state, so they line up
  // with seq_state. rst_l_adc therefore releases on the same edge that
  // leaves ADC_RST, including when enable drops.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rst_l_adc  <= 1'b1;
      hard_wreg  <= 1'b0;
      hard_start <= 1'b0;
    end else begin
      rst_l_adc  <= (state_d != S_ADC_RST);
      hard_wreg  <= (state_d == S_WREG);
      hard_start <= (state_q == S_WREG_WAIT) && (state_d == S_RUN);
    end
  end

`ifdef ADC045_AVG4_EN
  logic signed [25:0] acc_q;
  logic        [1:0]  phase_q;
  logic signed [25:0] sum;
  logic               cap;

  assign cap     = rise && (state_q == S_RUN);
  assign sum     = acc_q + {{2{adc045_data[23]}}, adc045_data};
  assign new_smp = cap && (phase_q == 2'd3);
  assign new_val = sum[25:2];

  // Four-sample accumulator. It is flushed outside RUN and on a watchdog
  // expiry, so a partial group never spans a re-run.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      acc_q   <= '0;
      phase_q <= '0;
    end else if ((state_q != S_RUN) || timeout_evt) begin
      acc_q   <= '0;
      phase_q <= '0;
    end else if (cap) begin
      if (phase_q == 2'd3) begin
        acc_q   <= '0;
        phase_q <= '0;
      end else begin
        acc_q   <= sum;
        phase_q <= phase_q + 2'd1;
      end
    end
  end
`else
  assign new_smp = rise && (state_q == S_RUN);
  assign new_val = adc045_data;
`endif

  assign overrun_set = new_smp & smp_valid & ~smp_ready;

  // One-deep output register. It loads when empty or when it is being
  // emptied in this cycle; otherwise the new sample is dropped.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      smp_valid <= 1'b0;
      smp_data  <= '0;
    end else if (new_smp && (!smp_valid || transfer)) begin
      smp_valid <= 1'b1;
      smp_data  <= new_val;
    end else if (transfer) begin
      smp_valid <= 1'b0;
    end
  end

  // Delivered-sample counter; wraps naturally at 2^32.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      sample_cnt <= '0;
    end else begin
      sample_cnt <= sample_cnt + 32'(transfer);
    end
  end

  // Sticky error flags. A set event in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      timeout_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      if (timeout_evt)  timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;
      if (overrun_set)  overrun_err <= 1'b1;
      else if (err_clr) overrun_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adc045_acq_seq.sv
// Directed testbench for adc045_acq_seq using reduced sequencing constants.
// Inputs are driven 1 ns after the rising clock edge, and outputs are read
// at the same point.

module tb_adc045_acq_seq;

  localparam int PWRUP     = 40;
  localparam int RST_LOW   = 1;
  localparam int RST_WAIT  = 10;
  localparam int WREG_WAIT = 5;
  localparam int TIMEOUT   = 100;
  localparam int RETRIES   = 3;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        enable;
  logic        restart;
  logic        rst_l_adc;
  logic        hard_wreg;
  logic        hard_start;
  logic        ready_sample;
  logic [23:0] adc045_data;
  logic        smp_valid;
  logic [23:0] smp_data;
  logic        smp_ready;
  logic [2:0]  seq_state;
  logic        timeout_err;
  logic        overrun_err;
  logic        err_clr;
  logic [31:0] sample_cnt;

  int checks   = 0;
  int failures = 0;

  // Clock generation: 100 MHz.
  always #5 clk = ~clk;

  adc045_acq_seq #(
    .PWRUP_CYC    (PWRUP),
    .RST_LOW_CYC  (RST_LOW),
    .RST_WAIT_CYC (RST_WAIT),
    .WREG_WAIT_CYC(WREG_WAIT),
    .TIMEOUT_CYC  (TIMEOUT),
    .MAX_RETRY    (RETRIES),
    .CNT_W        (16)
  ) dut (
    .clk         (clk),
    .rst_l       (rst_l),
    .enable      (enable),
    .restart     (restart),
    .rst_l_adc   (rst_l_adc),
    .hard_wreg   (hard_wreg),
    .hard_start  (hard_start),
    .ready_sample(ready_sample),
    .adc045_data (adc045_data),
    .smp_valid   (smp_valid),
    .smp_data    (smp_data),
    .smp_ready   (smp_ready),
    .seq_state   (seq_state),
    .timeout_err (timeout_err),
    .overrun_err (overrun_err),
    .err_clr     (err_clr),
    .sample_cnt  (sample_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic check_reset_outs(input string pfx);
    check({pfx, "_state"},       32'(seq_state),   0);
    check({pfx, "_rst_l_adc"},   32'(rst_l_adc),   1);
    check({pfx, "_hard_wreg"},   32'(hard_wreg),   0);
    check({pfx, "_hard_start"},  32'(hard_start),  0);
    check({pfx, "_smp_valid"},   32'(smp_valid),   0);
    check({pfx, "_smp_data"},    32'(smp_data),    0);
    check({pfx, "_timeout_err"}, 32'(timeout_err), 0);
    check({pfx, "_overrun_err"}, 32'(overrun_err), 0);
    check({pfx, "_sample_cnt"},  sample_cnt,       0);
  endtask

  // Bounded wait for a state; an expired bound shows up as a failed check.
  task automatic wait_state(input logic [2:0] target, input int max_cyc, input string tag,
                            output int n);
    n = 0;
    while ((seq_state !== target) && (n < max_cyc)) begin
      tick();
      n++;
    end
    check(tag, 32'(seq_state), 32'(target));
  endtask

  // One ready_sample pulse: high for one cycle, then low for one cycle.
  task automatic pulse_sample(input logic [23:0] d);
    ready_sample = 1'b1;
    adc045_data  = d;
    tick();
    ready_sample = 1'b0;
    tick();
  endtask

  initial begin
    int rst_at, rst_len, wreg_at, wreg_len, start_at, start_len;
    int vcnt, n, last_start, n_rst, n_wreg, n_start, starts_seen;
    logic fault_seen, prev_rst;
    logic [23:0] seen_data;

    rst_l        = 1'b0;
    enable       = 1'b0;
    restart      = 1'b0;
    ready_sample = 1'b0;
    adc045_data  = '0;
    smp_ready    = 1'b0;
    err_clr      = 1'b0;

    // Reset state
    repeat (3) tick();
    check_reset_outs("por");
    rst_l = 1'b1;
    tick();
    check("idle_hold", 32'(seq_state), 0);

    // Bring-up timing: cycle c is the state after the c-th edge with enable=1
    enable   = 1'b1;
    rst_at   = -1; rst_len = 0;
    wreg_at  = -1; wreg_len = 0;
    start_at = -1; start_len = 0;
    for (int c = 1; c <= 60; c++) begin
      tick();
      if (c == 1) check("pwrup_entry", 32'(seq_state), 1);
      if (!rst_l_adc) begin if (rst_at < 0) rst_at = c; rst_len++; end
      if (hard_wreg)  begin if (wreg_at < 0) wreg_at = c; wreg_len++; end
      if (hard_start) begin if (start_at < 0) start_at = c; start_len++; end
    end
    check("adc_rst_cycle",  rst_at,    41);
    check("adc_rst_width",  rst_len,   1);
    check("wreg_cycle",     wreg_at,   52);
    check("wreg_width",     wreg_len,  1);
    check("start_cycle",    start_at,  58);
    check("start_width",    start_len, 1);
    check("run_state",      32'(seq_state), 6);

`ifndef ADC045_AVG4_EN
    // Basic capture: ready_sample high 3 cycles yields one output
    smp_ready    = 1'b1;
    ready_sample = 1'b1;
    adc045_data  = 24'h7FFFFF;
    vcnt = 0;
    for (int c = 0; c < 5; c++) begin
      if (c == 3) ready_sample = 1'b0;
      tick();
      if (smp_valid) vcnt++;
      if (c == 0) begin
        check("cap_valid_lat1", 32'(smp_valid), 1);
        check("cap_data",       32'(smp_data),  32'h7FFFFF);
      end
    end
    check("cap_valid_cycles", vcnt, 1);
    check("cap_sample_cnt",   sample_cnt, 1);

    // Overrun: second rise while stalled is dropped
    smp_ready = 1'b0;
    pulse_sample(24'h000010);
    ready_sample = 1'b1;
    adc045_data  = 24'h000020;
    tick();
    ready_sample = 1'b0;
    check("ovr_valid", 32'(smp_valid),   1);
    check("ovr_data",  32'(smp_data),    32'h10);
    check("ovr_flag",  32'(overrun_err), 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("ovr_clr",       32'(overrun_err), 0);
    check("ovr_data_hold", 32'(smp_data),    32'h10);
    smp_ready = 1'b1;
    tick();
    check("ovr_drain_valid", 32'(smp_valid), 0);
    check("ovr_drain_cnt",   sample_cnt,     2);

    // Rise in the same cycle as a transfer loads, with no overrun
    smp_ready = 1'b0;
    pulse_sample(24'h000030);
    ready_sample = 1'b1;
    adc045_data  = 24'h000040;
    smp_ready    = 1'b1;
    tick();
    ready_sample = 1'b0;
    check("xfer_rise_valid", 32'(smp_valid),   1);
    check("xfer_rise_data",  32'(smp_data),    32'h40);
    check("xfer_rise_cnt",   sample_cnt,       3);
    check("xfer_rise_novr",  32'(overrun_err), 0);
    tick();
    check("xfer_rise_drain", 32'(smp_valid), 0);
    check("xfer_rise_cnt2",  sample_cnt,     4);

    // A set event in the same cycle as err_clr wins
    smp_ready = 1'b0;
    pulse_sample(24'h000050);
    ready_sample = 1'b1;
    adc045_data  = 24'h000060;
    err_clr      = 1'b1;
    tick();
    ready_sample = 1'b0;
    err_clr      = 1'b0;
    check("set_wins_flag", 32'(overrun_err), 1);
    check("set_wins_data", 32'(smp_data),    32'h50);
    smp_ready = 1'b1;
    tick();
    check("set_wins_cnt", sample_cnt, 5);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("set_wins_clr", 32'(overrun_err), 0);
`else
    // Averaging: 4, 8, -4, -8 -> 0, then 3 x4 -> 3
    smp_ready = 1'b1;
    vcnt = 0;
    seen_data = 24'hABCDEF;
    for (int i = 0; i < 4; i++) begin
      ready_sample = 1'b1;
      adc045_data  = (i == 0) ? 24'h000004 : (i == 1) ? 24'h000008 :
                     (i == 2) ? 24'hFFFFFC : 24'hFFFFF8;
      tick();
      if (smp_valid) begin vcnt++; seen_data = smp_data; end
      ready_sample = 1'b0;
      tick();
      if (smp_valid) begin vcnt++; seen_data = smp_data; end
    end
    check("avg_a_count", vcnt, 1);
    check("avg_a_data",  32'(seen_data), 0);
    vcnt = 0;
    for (int i = 0; i < 4; i++) begin
      ready_sample = 1'b1;
      adc045_data  = 24'h000003;
      tick();
      if (smp_valid) begin vcnt++; seen_data = smp_data; end
      ready_sample = 1'b0;
      tick();
      if (smp_valid) begin vcnt++; seen_data = smp_data; end
    end
    check("avg_b_count", vcnt, 1);
    check("avg_b_data",  32'(seen_data), 3);
    check("avg_cnt",     sample_cnt, 2);
`endif

    // Watchdog: three re-runs, then FAULT
    ready_sample = 1'b0;
    n_rst = 0; n_wreg = 0; n_start = 0; last_start = -1;
    fault_seen = 1'b0;
    prev_rst = rst_l_adc;
    starts_seen = 0;
    for (int c = 1; c <= 1000; c++) begin
      tick();
      if (!rst_l_adc && prev_rst) begin
        n_rst++;
        if (last_start >= 0) check("wd_gap_rerun", c - last_start, TIMEOUT);
      end
      if (hard_wreg) n_wreg++;
      if (hard_start) begin n_start++; last_start = c; end
      if (seq_state == 3'd7) begin
        if (last_start >= 0) check("wd_gap_fault", c - last_start, TIMEOUT);
        fault_seen = 1'b1;
        break;
      end
      prev_rst = rst_l_adc;
    end
    check("wd_fault_reached", 32'(fault_seen),  1);
    check("wd_rst_pulses",    n_rst,            RETRIES);
    check("wd_wreg_pulses",   n_wreg,           RETRIES);
    check("wd_start_pulses",  n_start,          RETRIES);
    check("wd_timeout_err",   32'(timeout_err), 1);
    repeat (5) tick();
    check("fault_hold",       32'(seq_state),  7);
    check("fault_rst_l_adc",  32'(rst_l_adc),  1);
    check("fault_hard_wreg",  32'(hard_wreg),  0);
    check("fault_hard_start", 32'(hard_start), 0);

    // Restart leaves FAULT; the sticky flag survives until err_clr
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check("restart_state",   32'(seq_state),   2);
    check("restart_rst_adc", 32'(rst_l_adc),   0);
    check("restart_tmo_err", 32'(timeout_err), 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("tmo_err_clr", 32'(timeout_err), 0);

    // Asynchronous reset in the middle of WREG_WAIT
    wait_state(3'd5, 50, "reach_wreg_wait", n);
    tick();
    #2 rst_l = 1'b0;
    #1;
    check_reset_outs("async_rst");
    n_start = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (hard_start) n_start++;
    end
    check("async_rst_no_start", n_start, 0);

    // Re-run after reset, then drop enable during the ADC reset pulse
    rst_l = 1'b1;
    wait_state(3'd2, 100, "rerun_adc_rst", n);
    check("rerun_adc_rst_cycle", n, PWRUP + 1);
    check("rerun_rst_l_adc_low", 32'(rst_l_adc), 0);
    enable = 1'b0;
    tick();
    check("en_drop_state",     32'(seq_state), 0);
    check("en_drop_rst_l_adc", 32'(rst_l_adc), 1);
    n_start = 0; n_wreg = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (hard_start) n_start++;
      if (hard_wreg)  n_wreg++;
    end
    check("en_drop_no_start", n_start, 0);
    check("en_drop_no_wreg",  n_wreg,  0);
    check("en_drop_idle",     32'(seq_state), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound for the whole run.
  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/adc045_acq_seq.md
Name: adc045_acq_seq

Overview:
- Sequencer in front of adc045_wrap.
- After system reset it generates the ADC bring-up sequence on rst_l_adc, hard_wreg and hard_start: power-up wait, ADC reset pulse, register write, then conversion start.
- Captures each 24-bit sample on the rising edge of ready_sample and presents it downstream on a valid/ready interface.
- Watchdog on ready_sample retries the bring-up and reports faults. Sits between adc045_wrap and the sample consumer (FIFO/DSP).

Parameters:
- PWRUP_CYC, 4000, clk cycles from rst_l release to ADC reset pulse
- RST_LOW_CYC, 1, width of rst_l_adc low pulse
- RST_WAIT_CYC, 1000, cycles after rst_l_adc release before hard_wreg
- WREG_WAIT_CYC, 500, cycles after hard_wreg before hard_start
- TIMEOUT_CYC, 20000, max cycles between ready_sample rises in RUN
- MAX_RETRY, 3, consecutive timeouts before FAULT
- CNT_W, 16, width of the internal wait/timeout counter; must hold the largest *_CYC value

Ports:
- clk  in  1  system clock (10 MHz)
- rst_l  in  1  asynchronous active-low reset
- enable  in  1  level; 0 forces IDLE from any state
- restart  in  1  pulse; re-runs bring-up from ADC_RST, clears FAULT
- rst_l_adc  out  1  to adc045_wrap; active-low ADC reset
- hard_wreg  out  1  to adc045_wrap; 1-cycle register-write pulse
- hard_start  out  1  to adc045_wrap; 1-cycle conversion-start pulse
- ready_sample  in  1  from adc045_wrap; sample available
- adc045_data  in  24  from adc045_wrap; two's-complement sample
- smp_valid  out  1  output sample valid
- smp_data  out  24  output sample
- smp_ready  in  1  downstream accept
- seq_state  out  3  current state encoding
- timeout_err  out  1  sticky; set on any watchdog expiry
- overrun_err  out  1  sticky; set when a sample is dropped
- err_clr  in  1  pulse; clears both sticky flags
- sample_cnt  out  32  samples accepted downstream, wraps at 2^32

Behaviour:
- Reset (rst_l=0, asynchronous):
  - state IDLE
  - rst_l_adc=1, hard_wreg=0, hard_start=0
  - smp_valid=0, smp_data=0
  - timeout_err=0, overrun_err=0, sample_cnt=0
  - retry counter=0, ready_sample edge register=0
- State encodings: IDLE=0, PWRUP=1, ADC_RST=2, RST_WAIT=3, WREG=4, WREG_WAIT=5, RUN=6, FAULT=7.
- IDLE: enable=1 -> PWRUP, counter loaded.
- PWRUP: counts PWRUP_CYC cycles -> ADC_RST.
- ADC_RST: rst_l_adc=0 for exactly RST_LOW_CYC cycles -> RST_WAIT.
- RST_WAIT: counts RST_WAIT_CYC cycles -> WREG.
- WREG: hard_wreg=1 for exactly 1 cycle -> WREG_WAIT.
- WREG_WAIT: counts WREG_WAIT_CYC cycles. On exit, hard_start=1 for exactly 1 cycle and the state goes to RUN on the same edge.
- RUN: watchdog counter clears on each ready_sample rise.
  - Counter reaches TIMEOUT_CYC: set timeout_err, retry+1.
  - If retry < MAX_RETRY -> ADC_RST; else -> FAULT.
- FAULT: all control outputs idle (rst_l_adc=1, hard_wreg=0, hard_start=0). Leaves only via restart (-> ADC_RST, retry=0) or enable=0 (-> IDLE).
- Retry counter clears to 0 on every ready_sample rise in RUN.
- restart in any state other than IDLE -> ADC_RST; any pending smp_valid is kept.
- enable=0 overrides restart.
- enable=0 in any state -> IDLE next cycle.
  - rst_l_adc is forced to 1 on that edge, even mid-pulse.
  - smp_valid is kept until handshake completes.
- Capture:
  - rise = ready_sample & ~ready_sample_q; captured only in RUN.
  - adc045_data is registered on the rise edge; smp_valid=1 the following cycle (1-cycle latency).
- Output handshake:
  - smp_valid holds with smp_data stable until smp_valid & smp_ready.
  - Transfer increments sample_cnt, which wraps 0xFFFFFFFF -> 0.
  - Rise while smp_valid=1 and smp_ready=0: new sample is dropped, old data is kept, overrun_err is set.
  - Rise in the same cycle as a transfer: new sample loads and smp_valid stays 1; no overrun.
- Sticky flags:
  - err_clr clears them.
  - A set event in the same cycle as err_clr wins (flag stays 1).

Optional Feature:
- ADC045_AVG4_EN defined:
  - RUN accumulates 4 consecutive captured samples, sign-extended, into a 26-bit signed sum.
  - On the 4th, smp_data = sum >>> 2 (arithmetic), and the accumulator clears.
  - smp_valid rate is one quarter of ready_sample.
  - Leaving RUN, or any timeout, clears the accumulator and its phase counter.
  - Overrun is evaluated only when an averaged result is produced.
- Not defined: every captured sample is output directly; no accumulator logic is present.

Test Plan:
- Sim params PWRUP=40, RST_LOW=1, RST_WAIT=10, WREG_WAIT=5; enable=1 after reset -> rst_l_adc low exactly 1 cycle at cycle 41; hard_wreg 1 cycle at cycle 52; hard_start 1 cycle at cycle 58; seq_state=6 afterwards.
- In RUN, ready_sample high for 3 cycles with adc045_data=0x7FFFFF, smp_ready=1 -> exactly one smp_valid cycle, 1 cycle after the rise, smp_data=0x7FFFFF, sample_cnt=1.
- smp_ready=0, two rises carrying 0x000010 then 0x000020 -> smp_data stays 0x000010 and overrun_err=1; err_clr then clears overrun_err.
- TIMEOUT_CYC=100, MAX_RETRY=3, no ready_sample -> three re-runs of the rst_l_adc/hard_wreg/hard_start sequence, then seq_state=7 with timeout_err=1; restart returns to ADC_RST.
- rst_l asserted mid-WREG_WAIT and enable dropped mid-ADC_RST -> all outputs at reset values with no hard_start; on enable drop, rst_l_adc returns to 1 on the next edge.
- With ADC045_AVG4_EN: samples 0x000004, 0x000008, 0xFFFFFC, 0xFFFFF8 -> one output, smp_data=0xFFFFFF-free sum 0 → smp_data=0x000000; then samples 0x000003 x4 -> smp_data=0x000003.
